// File: rtl/result_pkg.sv
// result_pkg
//   Shared definitions for the result serializer: the FSM state type,
//   its encoding (also the value driven on state_out) and the frame
//   header byte.
package result_pkg;

    typedef logic [2:0] state_t;

    // Encoding is visible on state_out, so these values are fixed.
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_COLLECT   = 3'd1;
    localparam state_t ST_SEND_HDR  = 3'd2;
    localparam state_t ST_SEND_CNT  = 3'd3;
    localparam state_t ST_SEND_DATA = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

endpackage

// File: rtl/result_serializer.sv
// result_serializer
//   Collects up to K_MAX result words from the search stage, then emits a
//   byte frame to a UART transmitter: A5, count, then each stored word
//   MSB byte first, in index order. Ready/valid byte handshake.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   start_in, k_in        arm a collection of min(k_in, K_MAX) words
//   result_in/_valid_in   incoming result words
//   end_in                close collection early
//   byte_out/_valid_out   serial byte stream, byte_ready_in accepts it
//   count_out             words stored in this frame
//   overflow_out          sticky: a word arrived outside COLLECT
//   done_out              one-cycle pulse after the last byte
//   state_out             FSM state for debug
//
// Assumes K_MAX >= 2 and DATA_WIDTH a multiple of 8 with a power-of-two
// byte count of at least 2.
module result_serializer
    import result_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K_MAX      = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic [15:0]                k_in,
    input  logic [DATA_WIDTH-1:0]      result_in,
    input  logic                       result_valid_in,
    input  logic                       end_in,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid_out,
    input  logic                       byte_ready_in,
    output logic [$clog2(K_MAX):0]     count_out,
    output logic                       overflow_out,
    output logic                       done_out,
    output logic [2:0]                 state_out
);

    localparam int CW = $clog2(K_MAX) + 1;
    localparam int IW = $clog2(K_MAX);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB);

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_klat;
    logic [IW-1:0]         r_widx;
    logic [BW-1:0]         r_bidx;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_buf [K_MAX];

    logic [CW-1:0]         w_kclamp;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_store;
    logic                  w_xfer;
    logic                  w_word_last;
    logic                  w_byte_last;
    logic [DATA_WIDTH-1:0] w_cur;
    logic [7:0]            w_bytes [NB];

    assign w_kclamp    = (k_in > 16'(K_MAX)) ? CW'(K_MAX) : k_in[CW-1:0];
    assign w_cnt_inc   = r_count + CW'(1);
    assign w_store     = (r_state == ST_COLLECT) && result_valid_in;
    assign w_xfer      = byte_valid_out && byte_ready_in;
    assign w_word_last = (CW'(r_widx) + CW'(1)) == r_count;
    assign w_byte_last = r_bidx == BW'(NB - 1);

    // Buffer is deliberately not reset; only written while collecting.
    always_ff @(posedge clk_in) begin
        if (w_store) r_buf[r_count[IW-1:0]] <= result_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_klat  <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // Any word offered outside COLLECT is lost; an accepted start
            // below overrides this and clears the flag.
            if (result_valid_in && r_state != ST_COLLECT) r_ovf <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_count <= '0;
                        r_widx  <= '0;
                        r_bidx  <= '0;
                        r_ovf   <= 1'b0;
                        r_klat  <= w_kclamp;
                        r_state <= (w_kclamp == '0) ? ST_SEND_HDR : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_store) begin
                        r_count <= w_cnt_inc;
                        if (w_cnt_inc == r_klat || end_in) r_state <= ST_SEND_HDR;
                    end else if (end_in) begin
                        r_state <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    if (w_xfer) r_state <= ST_SEND_CNT;
                end
                ST_SEND_CNT: begin
                    if (w_xfer) begin
                        r_widx  <= '0;
                        r_bidx  <= '0;
                        r_state <= (r_count == '0) ? ST_DONE : ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_xfer) begin
                        if (w_byte_last) begin
                            r_bidx <= '0;
                            if (w_word_last) r_state <= ST_DONE;
                            else             r_widx  <= r_widx + IW'(1);
                        end else begin
                            r_bidx <= r_bidx + BW'(1);
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Byte lane select: pure mux of registered state, buffer and indices,
    // so byte_out never depends on byte_ready_in.
    assign w_cur = r_buf[r_widx];

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_bytes[b] = w_cur[DATA_WIDTH-1-8*b -: 8];
        end
    end

    always_comb begin
        byte_out = 8'h00;
        case (r_state)
            ST_SEND_HDR:  byte_out = HDR_BYTE;
            ST_SEND_CNT:  byte_out = 8'(r_count);
            ST_SEND_DATA: byte_out = w_bytes[r_bidx];
            default:      byte_out = 8'h00;
        endcase
    end

    assign byte_valid_out = (r_state == ST_SEND_HDR) || (r_state == ST_SEND_CNT) ||
                            (r_state == ST_SEND_DATA);
    assign done_out       = (r_state == ST_DONE);
    assign count_out      = r_count;
    assign overflow_out   = r_ovf;
    assign state_out      = r_state;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer
//   Directed bench for result_serializer. Words pushed into the DUT are
//   mirrored into a word list; when collection closes the expected frame
//   (A5, count, big-endian data) is queued and compared byte by byte as
//   the DUT hands bytes over.
module tb_result_serializer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0;
    logic [15:0] k_in = '0;
    logic [31:0] result_in = '0;
    logic        result_valid_in = 1'b0;
    logic        end_in = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ready_in = 1'b0;
    logic [3:0]  count_out;
    logic        overflow_out;
    logic        done_out;
    logic [2:0]  state_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sbq[$];
    logic [31:0] wq[$];

    result_serializer #(.DATA_WIDTH(32), .K_MAX(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .k_in(k_in),
        .result_in(result_in), .result_valid_in(result_valid_in), .end_in(end_in),
        .byte_out(byte_out), .byte_valid_out(byte_valid_out),
        .byte_ready_in(byte_ready_in), .count_out(count_out),
        .overflow_out(overflow_out), .done_out(done_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at posedge+1, edge happens, back to posedge+1.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_start(input logic [15:0] k);
        start_in = 1'b1;
        k_in     = k;
        step();
        start_in = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit with_end, input bit keep);
        result_in       = w;
        result_valid_in = 1'b1;
        end_in          = with_end;
        step();
        result_valid_in = 1'b0;
        end_in          = 1'b0;
        if (keep) wq.push_back(w);
    endtask

    task automatic push_frame();
        sbq.push_back(8'hA5);
        sbq.push_back(8'(wq.size()));
        foreach (wq[i]) begin
            sbq.push_back(wq[i][31:24]);
            sbq.push_back(wq[i][23:16]);
            sbq.push_back(wq[i][15:8]);
            sbq.push_back(wq[i][7:0]);
        end
        wq.delete();
    endtask

    // Runs the byte handshake until done_out, the cycle budget, or
    // stop_after transfers. Checks every transferred byte against the
    // scoreboard and that a stalled byte holds still.
    task automatic drain(input int maxc, input bit rnd, input int stop_after,
                         output int n, output int first, output int last, output int donec);
        int   cyc = 0;
        bit   stall = 0;
        logic [7:0] held = '0;
        logic [7:0] e;
        n = 0; first = -1; last = -1; donec = -1;
        while (cyc < maxc && donec < 0 && !(stop_after > 0 && n >= stop_after)) begin
            byte_ready_in = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
            @(negedge clk_in);
            if (stall) begin
                chk("stall_valid", 32'(byte_valid_out), 32'd1);
                chk("stall_stable", 32'(byte_out), 32'(held));
            end
            if (byte_valid_out && byte_ready_in) begin
                chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk($sformatf("byte%0d", n), 32'(byte_out), 32'(e));
                end
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            stall = byte_valid_out && !byte_ready_in;
            held  = byte_out;
            if (done_out) donec = cyc;
            @(posedge clk_in);
            #1;
            cyc++;
        end
        byte_ready_in = 1'b0;
        if (stop_after == 0) chk("done_seen", 32'(donec >= 0), 32'd1);
    endtask

    task automatic after_done();
        @(negedge clk_in);
        chk("done_one_cycle", 32'(done_out), 32'd0);
        chk("back_idle", 32'(state_out), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        @(posedge clk_in);
        #1;
    endtask

    task automatic three_words();
        do_start(16'd3);
        send_word(32'h11223344, 0, 1);
        send_word(32'h55667788, 0, 1);
        send_word(32'h99AABBCC, 0, 1);
        chk("k3_count", 32'(count_out), 32'd3);
        push_frame();
    endtask

    initial begin
        int n, f, l, d;

        // Reset values
        #2;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_valid", 32'(byte_valid_out), 32'd0);
        chk("rst_byte", 32'(byte_out), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        step(); step();
        rst_in = 1'b1;
        step();

        // Three words, ready held high: 14 back-to-back bytes then done.
        three_words();
        drain(100, 0, 0, n, f, l, d);
        chk("k3_nbytes", 32'(n), 32'd14);
        chk("k3_no_bubble", 32'(l - f + 1), 32'd14);
        chk("k3_done_cycle", 32'(d), 32'(l + 1));
        chk("k3_ovf", 32'(overflow_out), 32'd0);
        after_done();

        // k clamped to K_MAX, ninth word dropped with overflow.
        do_start(16'd20);
        for (int i = 0; i < 8; i++) send_word(32'hA0000000 + 32'(i * 32'h01010101), 0, 1);
        chk("kmax_state", 32'(state_out), 32'd2);
        send_word(32'hDEADBEEF, 0, 0);
        chk("kmax_count", 32'(count_out), 32'd8);
        chk("kmax_ovf", 32'(overflow_out), 32'd1);
        push_frame();
        drain(200, 0, 0, n, f, l, d);
        chk("kmax_nbytes", 32'(n), 32'd34);
        chk("kmax_ovf_sticky", 32'(overflow_out), 32'd1);
        after_done();

        // Early end with a word on the same cycle.
        do_start(16'd4);
        chk("start_clears_ovf", 32'(overflow_out), 32'd0);
        send_word(32'h01020304, 0, 1);
        send_word(32'h05060708, 0, 1);
        send_word(32'h090A0B0C, 1, 1);
        chk("end_count", 32'(count_out), 32'd3);
        chk("end_state", 32'(state_out), 32'd2);
        push_frame();
        drain(100, 0, 0, n, f, l, d);
        chk("end_nbytes", 32'(n), 32'd14);
        after_done();

        // k = 0: header and zero count only.
        do_start(16'd0);
        chk("k0_state", 32'(state_out), 32'd2);
        push_frame();
        drain(50, 0, 0, n, f, l, d);
        chk("k0_nbytes", 32'(n), 32'd2);
        chk("k0_done_cycle", 32'(d), 32'(l + 1));
        after_done();

        // Random ready back-pressure, same frame as the first.
        three_words();
        drain(400, 1, 0, n, f, l, d);
        chk("rnd_nbytes", 32'(n), 32'd14);
        after_done();

        // Start outside IDLE is ignored.
        do_start(16'd2);
        do_start(16'd5);
        chk("restart_state", 32'(state_out), 32'd1);
        send_word(32'hCAFEF00D, 0, 1);
        send_word(32'h12345678, 0, 1);
        chk("restart_count", 32'(count_out), 32'd2);
        push_frame();
        drain(100, 0, 0, n, f, l, d);
        chk("restart_nbytes", 32'(n), 32'd10);
        after_done();

        // Reset after the fifth transfer aborts the frame.
        three_words();
        drain(100, 0, 5, n, f, l, d);
        chk("abort_n", 32'(n), 32'd5);
        rst_in = 1'b0;
        #1;
        chk("abort_valid", 32'(byte_valid_out), 32'd0);
        chk("abort_state", 32'(state_out), 32'd0);
        chk("abort_count", 32'(count_out), 32'd0);
        chk("abort_byte", 32'(byte_out), 32'd0);
        sbq.delete();
        step(); step();
        rst_in = 1'b1;
        step();
        chk("post_rst_idle", 32'(state_out), 32'd0);
        three_words();
        drain(100, 0, 0, n, f, l, d);
        chk("post_rst_nbytes", 32'(n), 32'd14);
        chk("post_rst_no_bubble", 32'(l - f + 1), 32'd14);
        after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one result word.
REQ-002 SHALL have parameter K_MAX, default 8: buffer depth in words.
REQ-003 SHALL have port clk_in, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start_in, input, 1: pulse that arms a new collection.
REQ-006 SHALL have port k_in, input, 16: requested result count, sampled on an accepted start.
REQ-007 SHALL have port result_in, input, DATA_WIDTH: result word from the search stage (top_k_out).
REQ-008 SHALL have port result_valid_in, input, 1: result_in is valid this cycle (search-stage valid_out).
REQ-009 SHALL have port end_in, input, 1: the search stage has finished early; close collection.
REQ-010 SHALL have port byte_out, output, 8: serial byte to the UART transmitter.
REQ-011 SHALL have port byte_valid_out, output, 1: byte_out is valid.
REQ-012 SHALL have port byte_ready_in, input, 1: the transmitter accepts byte_out.
REQ-013 SHALL have port count_out, output, $clog2(K_MAX)+1: number of words stored.
REQ-014 SHALL have port overflow_out, output, 1: sticky flag, a result was dropped.
REQ-015 SHALL have port done_out, output, 1: one-cycle pulse when the frame is complete.
REQ-016 SHALL have port state_out, output, 3: current FSM state, for debug.

Function
REQ-017 SHALL implement states IDLE=0, COLLECT=1, SEND_HDR=2, SEND_CNT=3, SEND_DATA=4, DONE=5.
REQ-018 IDLE: start_in=1 -> clear count and byte index, latch k_lat=min(k_in,K_MAX), go to COLLECT; if k_lat=0, go to SEND_HDR instead.
REQ-019 COLLECT: result_valid_in=1 -> store result_in at buf[count], count+1; when the incremented count equals k_lat, go to SEND_HDR on the same edge.
REQ-020 COLLECT: end_in=1 -> go to SEND_HDR; if result_valid_in is also 1 that cycle, store the word first.
REQ-021 result_valid_in in any state other than COLLECT SHALL drop the word and set overflow_out; overflow_out clears only on an accepted start or on reset.
REQ-022 start_in outside IDLE SHALL be ignored.
REQ-023 SEND_HDR SHALL emit byte 0xA5; SEND_CNT SHALL emit count zero-extended to 8 bits.
REQ-024 SEND_DATA SHALL emit each word big-endian (MSB byte first, DATA_WIDTH/8 bytes), words in index order 0..count-1.
REQ-025 count=0 SHALL skip SEND_DATA: SEND_CNT goes to DONE.
REQ-026 Handshake: byte_valid_out=1 in SEND_* states; byte_out held stable until byte_valid_out & byte_ready_in; a transfer advances the byte or state on that edge.
REQ-027 byte_ready_in held high SHALL give one byte per cycle with no bubbles, including across state changes.
REQ-028 DONE SHALL assert done_out for exactly one cycle, then go to IDLE; byte_valid_out=0 in DONE.
REQ-029 byte_out SHALL be driven from registers or a mux of registered buffer and index, with no combinational path from byte_ready_in.

Reset
REQ-030 rst_in=0 SHALL asynchronously force: state IDLE, count 0, byte and word index 0, overflow_out 0, done_out 0, byte_valid_out 0, byte_out 0x00.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 Reset mid-frame SHALL abort the frame with no further bytes; after release the block waits for start_in.

Structure
REQ-033 Package result_pkg SHALL hold the state enum, HDR_BYTE=8'hA5 and the state_out encoding.
REQ-034 No sub-module is required; the buffer SHALL be an inferred register array of K_MAX x DATA_WIDTH.

Verification
REQ-035 start, k_in=3; words 0x11223344, 0x55667788, 0x99AABBCC; ready=1 -> bytes A5 03 11 22 33 44 55 66 77 88 99 AA BB CC on consecutive cycles, then one-cycle done_out.
REQ-036 start, k_in=20 with K_MAX=8; 8 words, then a 9th -> count=8, overflow_out=1, frame 34 bytes long.
REQ-037 start, k_in=4; 2 words, then end_in with a 3rd word on the same cycle -> count=3, frame A5 03 plus 12 data bytes.
REQ-038 start, k_in=0 -> bytes A5 00, then done_out; no data bytes.
REQ-039 byte_ready_in toggling at random at 30% -> byte_out stable while stalled; byte sequence identical to REQ-035.
REQ-040 rst_in low after the 5th byte transfer -> byte_valid_out=0 immediately, state_out=0; a new start gives a correct full frame.
